// File: rtl/cfg_loader_pkg.sv
// Shared types and sizing helpers for the BL/WL configuration loader.
package cfg_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Default geometry of the fabric's config region
    localparam int DEF_BL_WIDTH = 514;
    localparam int DEF_WL_WIDTH = 407;
    localparam int DEF_IN_WIDTH = 32;
    localparam int DEF_WL_PULSE = 2;

    // Number of input words needed to cover one bitline row
    function automatic int words_per_row(input int bl_width, input int in_width);
        return (bl_width + in_width - 1) / in_width;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bl_row_assembler.sv
// Collects the input words of one bitline row into a BL_WIDTH-bit buffer.
// Word k bit j lands on row bit k*IN_WIDTH+j; bits past BL_WIDTH in the last
// word have no destination and are simply dropped.
module bl_row_assembler
    import cfg_loader_pkg::*;
#(
    parameter int BL_WIDTH = DEF_BL_WIDTH,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    localparam int WPR     = words_per_row(BL_WIDTH, IN_WIDTH),
    localparam int WORD_W  = cnt_width(WPR)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic [WORD_W-1:0]   i_word_idx,
    input  logic [IN_WIDTH-1:0] i_word,
    output logic [0:BL_WIDTH-1] o_row,
    output logic                o_last_word
);

    logic [0:BL_WIDTH-1] r_row;
    logic [0:BL_WIDTH-1] w_row_next;
    logic [WPR-1:0]      w_word_sel;

    genvar gk, gb;
    generate
        for (gk = 0; gk < WPR; gk++) begin : g_sel
            assign w_word_sel[gk] = i_wr_en && (i_word_idx == WORD_W'(gk));
        end

        // Only in-range row bits exist, so the pad bits of the last word are truncated here
        for (gb = 0; gb < BL_WIDTH; gb++) begin : g_bit
            localparam int K = gb / IN_WIDTH;
            localparam int J = gb % IN_WIDTH;
            assign w_row_next[gb] = w_word_sel[K] ? i_word[J] : r_row[gb];
        end
    endgenerate

    // Row buffer register, updated with the word being written this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
        end else begin
            r_row <= w_row_next;
        end
    end

    // Merged view lets the top capture the full row on the edge the last word lands
    assign o_row       = w_row_next;
    assign o_last_word = (i_word_idx == WORD_W'(WPR - 1));

endmodule

// File: rtl/bl_wl_config_loader.sv
// Bitline/wordline config-memory programmer: takes a 32-bit word stream,
// assembles each BL row, then strobes that row's wordline for WL_PULSE cycles
// with a one-cycle BL guard before and after the strobe.
module bl_wl_config_loader
    import cfg_loader_pkg::*;
#(
    parameter int BL_WIDTH = DEF_BL_WIDTH,
    parameter int WL_WIDTH = DEF_WL_WIDTH,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int WL_PULSE = DEF_WL_PULSE
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [0:BL_WIDTH-1] bl_config_region_0,
    output logic [0:WL_WIDTH-1] wl_config_region_0,
    output logic                busy,
    output logic                done
);

    localparam int WPR     = words_per_row(BL_WIDTH, IN_WIDTH);
    localparam int ROW_W   = cnt_width(WL_WIDTH);
    localparam int WORD_W  = cnt_width(WPR);
    localparam int PULSE_W = cnt_width(WL_PULSE);

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(WL_WIDTH - 1);
    localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(WL_PULSE - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [ROW_W-1:0]     r_row;
    logic [ROW_W-1:0]     w_row_next;
    logic [WORD_W-1:0]    r_word;
    logic [WORD_W-1:0]    w_word_next;
    logic [PULSE_W-1:0]   r_pulse;
    logic [PULSE_W-1:0]   w_pulse_next;

    logic                 r_s_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [0:BL_WIDTH-1]  r_bl;
    logic [0:WL_WIDTH-1]  r_wl;

    logic                 w_accept;
    logic                 w_last_word;
    logic                 w_load_bl;
    logic                 w_clear_bl;
    logic [0:BL_WIDTH-1]  w_row_bits;
    logic [0:WL_WIDTH-1]  w_wl_sel;

    // s_ready is high exactly while in LOAD, so it doubles as the LOAD qualifier
    assign w_accept = s_valid && r_s_ready;

    bl_row_assembler #(
        .BL_WIDTH (BL_WIDTH),
        .IN_WIDTH (IN_WIDTH)
    ) u_row_asm (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (w_accept),
        .i_word_idx  (r_word),
        .i_word      (s_data),
        .o_row       (w_row_bits),
        .o_last_word (w_last_word)
    );

    genvar gr;
    generate
        for (gr = 0; gr < WL_WIDTH; gr++) begin : g_wl
            assign w_wl_sel[gr] = (r_row == ROW_W'(gr));
        end
    endgenerate

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_word  <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_word  <= w_word_next;
            r_pulse <= w_pulse_next;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_word_next  = r_word;
        w_pulse_next = r_pulse;
        w_load_bl    = 1'b0;
        w_clear_bl   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD;
                    w_row_next   = '0;
                    w_word_next  = '0;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (w_last_word) begin
                        w_state_next = SETUP;
                        w_load_bl    = 1'b1;
                    end else begin
                        w_word_next = r_word + WORD_W'(1);
                    end
                end
            end
            SETUP: begin
                w_state_next = PULSE;
                w_pulse_next = '0;
            end
            PULSE: begin
                if (r_pulse == LAST_PULSE) begin
                    w_state_next = HOLD;
                end else begin
                    w_pulse_next = r_pulse + PULSE_W'(1);
                end
            end
            HOLD: begin
                if (r_row == LAST_ROW) begin
                    w_state_next = DONE;
                    w_clear_bl   = 1'b1;
                end else begin
                    w_state_next = LOAD;
                    w_row_next   = r_row + ROW_W'(1);
                    w_word_next  = '0;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wl      <= '0;
            r_bl      <= '0;
        end else begin
            r_s_ready <= (w_state_next == LOAD);
            r_busy    <= (w_state_next != IDLE) && (w_state_next != DONE);
            r_done    <= (w_state_next == DONE);
            r_wl      <= (w_state_next == PULSE) ? w_wl_sel : '0;
            if (w_load_bl) begin
                r_bl <= w_row_bits;
            end else if (w_clear_bl) begin
                r_bl <= '0;
            end
        end
    end

    assign s_ready            = r_s_ready;
    assign busy               = r_busy;
    assign done               = r_done;
    assign bl_config_region_0 = r_bl;
    assign wl_config_region_0 = r_wl;

endmodule
